// File: rtl/id_ex_stage_reg_pkg.sv
// Shared core definitions for the decode/execute boundary: result-mux
// encodings, branch type codes and the packed control word that travels
// from the control unit into the execute stage.
package id_ex_stage_reg_pkg;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_BLT  = 3'b011,
    BR_BGE  = 3'b100,
    BR_BLTU = 3'b101,
    BR_BGEU = 3'b110
  } branch_type_e;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic [2:0] branch;
    logic [3:0] alu_control;
    logic       alu_src;
    logic       alu_src_a;
    logic       pc_target_src;
  } ctrl_t;

  // A bubble is an all-zero control word: no write-back, no store, no
  // jump, BR_NONE and the ALU result selected.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_reg_hazard_detect.sv
// Purely combinational load-use and redirect hazard logic. A redirect from
// execute wins over a load-use stall because the decode instruction is on
// the wrong path and is about to be flushed anyway.
module hazard_detect
  import id_ex_stage_reg_pkg::*;
(
  input  logic       valid_e,
  input  logic [1:0] result_src_e,
  input  logic       reg_write_e,
  input  logic [4:0] rd_e,
  input  logic       valid_d,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic       pc_src_e,
  output logic       load_use,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_d
);

  // rs2 is always compared, even for instructions that ignore it; the
  // occasional extra stall is cheaper than decoding operand usage here.
  always_comb begin
    load_use = valid_e && (result_src_e == RES_MEM) && reg_write_e &&
               (rd_e != 5'd0) && valid_d &&
               ((rd_e == rs1_d) || (rd_e == rs2_d));
    flush_d  = pc_src_e;
    stall_f  = load_use && !pc_src_e;
    stall_d  = load_use && !pc_src_e;
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register. Captures the decode control word and operands,
// loads a deterministic bubble on a load-use stall or an execute redirect,
// and keeps a saturating count of load-use stall cycles.
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic            JumpD,
  input  logic            ALUSrcD,
  input  logic            ALUSrcAD,
  input  logic            PCTargetSrcD,
  input  logic [1:0]      ResultSrcD,
  input  logic [2:0]      BranchD,
  input  logic [3:0]      ALUControlD,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      RdD,
  input  logic            ValidD,
  input  logic            PCSrcE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            ALUSrcE,
  output logic            ALUSrcAE,
  output logic            PCTargetSrcE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      BranchE,
  output logic [3:0]      ALUControlE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic            ValidE,
  output logic            StallF,
  output logic            StallD,
  output logic            FlushD,
  output logic [CNT_W-1:0] LoadUseCnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctrl_t            ctrl_d;
  ctrl_t            ctrl_e;
  logic [XLEN-1:0]  rd1_e, rd2_e, pc_e, imm_e, pc_plus4_e;
  logic [4:0]       rs1_e, rs2_e, rd_e;
  logic             valid_e;
  logic [CNT_W-1:0] load_use_cnt;
  logic             load_use;
  logic             squash;

  assign ctrl_d = '{reg_write:     RegWriteD,
                    result_src:    ResultSrcD,
                    mem_write:     MemWriteD,
                    jump:          JumpD,
                    branch:        BranchD,
                    alu_control:   ALUControlD,
                    alu_src:       ALUSrcD,
                    alu_src_a:     ALUSrcAD,
                    pc_target_src: PCTargetSrcD};

  hazard_detect u_hazard_detect (
    .valid_e      (valid_e),
    .result_src_e (ctrl_e.result_src),
    .reg_write_e  (ctrl_e.reg_write),
    .rd_e         (rd_e),
    .valid_d      (ValidD),
    .rs1_d        (Rs1D),
    .rs2_d        (Rs2D),
    .pc_src_e     (PCSrcE),
    .load_use     (load_use),
    .stall_f      (StallF),
    .stall_d      (StallD),
    .flush_d      (FlushD)
  );

  assign squash = PCSrcE || load_use;

  // Execute-stage register: a bubble on any squash, otherwise copy decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_e     <= CTRL_BUBBLE;
      valid_e    <= 1'b0;
      rd1_e      <= '0;
      rd2_e      <= '0;
      pc_e       <= '0;
      imm_e      <= '0;
      pc_plus4_e <= '0;
      rs1_e      <= '0;
      rs2_e      <= '0;
      rd_e       <= '0;
    end else if (squash) begin
      ctrl_e     <= CTRL_BUBBLE;
      valid_e    <= 1'b0;
      rd1_e      <= '0;
      rd2_e      <= '0;
      pc_e       <= '0;
      imm_e      <= '0;
      pc_plus4_e <= '0;
      rs1_e      <= '0;
      rs2_e      <= '0;
      rd_e       <= '0;
    end else begin
      ctrl_e     <= ctrl_d;
      valid_e    <= ValidD;
      rd1_e      <= RD1D;
      rd2_e      <= RD2D;
      pc_e       <= PCD;
      imm_e      <= ImmExtD;
      pc_plus4_e <= PCPlus4D;
      rs1_e      <= Rs1D;
      rs2_e      <= Rs2D;
      rd_e       <= RdD;
    end
  end

  // Saturating count of real load-use stalls; redirect cycles are not stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_use_cnt <= '0;
    end else if (load_use && !PCSrcE && (load_use_cnt != CNT_MAX)) begin
      load_use_cnt <= load_use_cnt + CNT_W'(1);
    end
  end

  assign RegWriteE    = ctrl_e.reg_write;
  assign ResultSrcE   = ctrl_e.result_src;
  assign MemWriteE    = ctrl_e.mem_write;
  assign JumpE        = ctrl_e.jump;
  assign BranchE      = ctrl_e.branch;
  assign ALUControlE  = ctrl_e.alu_control;
  assign ALUSrcE      = ctrl_e.alu_src;
  assign ALUSrcAE     = ctrl_e.alu_src_a;
  assign PCTargetSrcE = ctrl_e.pc_target_src;
  assign RD1E         = rd1_e;
  assign RD2E         = rd2_e;
  assign PCE          = pc_e;
  assign ImmExtE      = imm_e;
  assign PCPlus4E     = pc_plus4_e;
  assign Rs1E         = rs1_e;
  assign Rs2E         = rs2_e;
  assign RdE          = rd_e;
  assign ValidE       = valid_e;
  assign LoadUseCnt   = load_use_cnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Table-driven bench for id_ex_stage_reg, built with a 2-bit stall counter
// so saturation is reachable, plus hand-written reset sequences.
module tb_id_ex_stage_reg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 2;

  logic            clk;
  logic            rst;
  logic            RegWriteD, MemWriteD, JumpD, ALUSrcD, ALUSrcAD, PCTargetSrcD;
  logic [1:0]      ResultSrcD;
  logic [2:0]      BranchD;
  logic [3:0]      ALUControlD;
  logic [XLEN-1:0] RD1D, RD2D, PCD, ImmExtD, PCPlus4D;
  logic [4:0]      Rs1D, Rs2D, RdD;
  logic            ValidD, PCSrcE;
  logic            RegWriteE, MemWriteE, JumpE, ALUSrcE, ALUSrcAE, PCTargetSrcE;
  logic [1:0]      ResultSrcE;
  logic [2:0]      BranchE;
  logic [3:0]      ALUControlE;
  logic [XLEN-1:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
  logic [4:0]      Rs1E, Rs2E, RdE;
  logic            ValidE, StallF, StallD, FlushD;
  logic [CNT_W-1:0] LoadUseCnt;

  id_ex_stage_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD),
    .ALUSrcD(ALUSrcD), .ALUSrcAD(ALUSrcAD), .PCTargetSrcD(PCTargetSrcD),
    .ResultSrcD(ResultSrcD), .BranchD(BranchD), .ALUControlD(ALUControlD),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .ImmExtD(ImmExtD), .PCPlus4D(PCPlus4D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ValidD(ValidD), .PCSrcE(PCSrcE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
    .ALUSrcE(ALUSrcE), .ALUSrcAE(ALUSrcAE), .PCTargetSrcE(PCTargetSrcE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ValidE(ValidE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .LoadUseCnt(LoadUseCnt)
  );

  typedef struct {
    logic        validD;
    logic [1:0]  resD;
    logic        rwD;
    logic [4:0]  rdD;
    logic [4:0]  rs1D;
    logic [4:0]  rs2D;
    logic        pcSrc;
    logic [31:0] rd1;
    logic        expStall;
    logic        expFlush;
    logic        expBubble;
    logic [1:0]  expCnt;
  } vec_t;

  vec_t vecs[19];
  int   passCount;
  int   totalCount;
  logic [190:0] actE;

  assign actE = {ValidE, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE,
                 ALUControlE, ALUSrcE, ALUSrcAE, PCTargetSrcE,
                 RD1E, RD2E, PCE, ImmExtE, PCPlus4E, Rs1E, Rs2E, RdE};

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Builds one table row.
  function automatic vec_t mk(logic v, logic [1:0] res, logic rw, logic [4:0] rd,
                              logic [4:0] rs1, logic [4:0] rs2, logic pc, logic [31:0] d1,
                              logic st, logic fl, logic bub, logic [1:0] cnt);
    vec_t r;
    r.validD = v;   r.resD = res; r.rwD = rw;  r.rdD = rd;
    r.rs1D = rs1;   r.rs2D = rs2; r.pcSrc = pc; r.rd1 = d1;
    r.expStall = st; r.expFlush = fl; r.expBubble = bub; r.expCnt = cnt;
    return r;
  endfunction

  // Expected execute-stage image when a row passes straight through.
  function automatic logic [190:0] expE(vec_t v);
    logic [31:0] swapped;
    swapped = {v.rd1[15:0], v.rd1[31:16]};
    return {v.validD, v.rwD, v.resD, 1'b0, 1'b0, 3'b010, 4'h5, 1'b1, 1'b0, 1'b1,
            v.rd1, ~v.rd1, v.rd1 + 32'h100, swapped, v.rd1 + 32'h104,
            v.rs1D, v.rs2D, v.rdD};
  endfunction

  // Drives the decode-side inputs for one row; fixed fields derive from rd1.
  task automatic applyStimulus(input vec_t v);
    ValidD       = v.validD;
    ResultSrcD   = v.resD;
    RegWriteD    = v.rwD;
    RdD          = v.rdD;
    Rs1D         = v.rs1D;
    Rs2D         = v.rs2D;
    PCSrcE       = v.pcSrc;
    MemWriteD    = 1'b0;
    JumpD        = 1'b0;
    BranchD      = 3'b010;
    ALUControlD  = 4'h5;
    ALUSrcD      = 1'b1;
    ALUSrcAD     = 1'b0;
    PCTargetSrcD = 1'b1;
    RD1D         = v.rd1;
    RD2D         = ~v.rd1;
    PCD          = v.rd1 + 32'h100;
    ImmExtD      = {v.rd1[15:0], v.rd1[31:16]};
    PCPlus4D     = v.rd1 + 32'h104;
  endtask

  task automatic checkOutput(input string name, input logic [190:0] act, input logic [190:0] exp);
    totalCount++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    else
      passCount++;
  endtask

  initial begin
    vec_t r0, ld, dep;
    passCount  = 0;
    totalCount = 0;

    // Reset with random decode inputs: everything must read zero.
    rst = 1'b0;
    r0 = mk(1'b1, 2'b00, 1'b1, 5'd7, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)),
            1'b0, $urandom(), 1'b0, 1'b0, 1'b0, 2'd0);
    applyStimulus(r0);
    @(posedge clk); @(posedge clk); #1;
    checkOutput("reset_E", actE, '0);
    checkOutput("reset_cnt", {189'd0, LoadUseCnt}, '0);
    checkOutput("reset_stallF", {190'd0, StallF}, '0);
    checkOutput("reset_stallD", {190'd0, StallD}, '0);
    checkOutput("reset_flushD", {190'd0, FlushD}, '0);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("release_E", actE, expE(r0));
    checkOutput("release_cnt", {189'd0, LoadUseCnt}, '0);

    //            v  res    rw rd  rs1 rs2 pc  rd1           st fl bub cnt
    vecs[0]  = mk(1, 2'b01, 1, 5,  7,  0,  0, 32'hA000_0000, 0, 0, 0, 0);
    vecs[1]  = mk(1, 2'b00, 1, 6,  5,  3,  0, 32'hA000_0001, 1, 0, 1, 1);
    vecs[2]  = mk(1, 2'b00, 1, 6,  5,  3,  0, 32'hA000_0001, 0, 0, 0, 1);
    vecs[3]  = mk(1, 2'b01, 1, 0,  6,  0,  0, 32'hA000_0003, 0, 0, 0, 1);
    vecs[4]  = mk(1, 2'b00, 1, 8,  0,  0,  0, 32'hA000_0004, 0, 0, 0, 1);
    vecs[5]  = mk(1, 2'b01, 1, 9,  8,  0,  0, 32'hA000_0005, 0, 0, 0, 1);
    vecs[6]  = mk(1, 2'b00, 1, 10, 1,  9,  1, 32'hA000_0006, 0, 1, 1, 1);
    vecs[7]  = mk(1, 2'b01, 1, 11, 0,  0,  0, 32'hA000_0007, 0, 0, 0, 1);
    vecs[8]  = mk(1, 2'b00, 1, 12, 0,  11, 0, 32'hA000_0008, 1, 0, 1, 2);
    vecs[9]  = mk(1, 2'b00, 1, 12, 0,  11, 0, 32'hA000_0008, 0, 0, 0, 2);
    vecs[10] = mk(1, 2'b01, 1, 13, 0,  0,  0, 32'hA000_000A, 0, 0, 0, 2);
    vecs[11] = mk(0, 2'b01, 1, 14, 13, 13, 0, 32'hA000_000B, 0, 0, 0, 2);
    vecs[12] = mk(1, 2'b00, 1, 15, 14, 14, 0, 32'hA000_000C, 0, 0, 0, 2);
    vecs[13] = mk(1, 2'b01, 1, 16, 0,  0,  0, 32'hA000_000D, 0, 0, 0, 2);
    vecs[14] = mk(1, 2'b00, 1, 17, 16, 0,  0, 32'hA000_000E, 1, 0, 1, 3);
    vecs[15] = mk(1, 2'b00, 1, 17, 16, 0,  0, 32'hA000_000E, 0, 0, 0, 3);
    vecs[16] = mk(1, 2'b01, 1, 18, 0,  0,  0, 32'hA000_0010, 0, 0, 0, 3);
    vecs[17] = mk(1, 2'b00, 1, 19, 0,  18, 0, 32'hA000_0011, 1, 0, 1, 3);
    vecs[18] = mk(1, 2'b00, 1, 19, 0,  18, 0, 32'hA000_0011, 0, 0, 0, 3);

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("row%0d_stallF", i), {190'd0, StallF}, {190'd0, vecs[i].expStall});
      checkOutput($sformatf("row%0d_stallD", i), {190'd0, StallD}, {190'd0, vecs[i].expStall});
      checkOutput($sformatf("row%0d_flushD", i), {190'd0, FlushD}, {190'd0, vecs[i].expFlush});
      @(posedge clk); #1;
      checkOutput($sformatf("row%0d_E", i), actE, vecs[i].expBubble ? '0 : expE(vecs[i]));
      checkOutput($sformatf("row%0d_cnt", i), {189'd0, LoadUseCnt}, {189'd0, vecs[i].expCnt});
    end

    // Asynchronous reset in the middle of a load-use stall cycle.
    ld  = mk(1, 2'b01, 1, 20, 0, 0, 0, 32'hB000_0000, 0, 0, 0, 3);
    dep = mk(1, 2'b00, 1, 21, 20, 0, 0, 32'hB000_0001, 0, 0, 0, 0);
    applyStimulus(ld);
    @(posedge clk); #1;
    checkOutput("midrst_load_E", actE, expE(ld));
    applyStimulus(dep);
    #1;
    checkOutput("midrst_stall_before", {190'd0, StallF}, {190'd0, 1'b1});
    #1 rst = 1'b0;
    #1;
    checkOutput("midrst_stallF", {190'd0, StallF}, '0);
    checkOutput("midrst_stallD", {190'd0, StallD}, '0);
    checkOutput("midrst_E", actE, '0);
    checkOutput("midrst_cnt", {189'd0, LoadUseCnt}, '0);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_after_E", actE, expE(dep));
    checkOutput("midrst_after_cnt", {189'd0, LoadUseCnt}, '0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
